// File: rtl/mesh_fabric_model.sv
// -----------------------------------------------------------------------------
// mesh_fabric_model
//
// Terminal-level model of a ROWS x COLUMS mesh network-on-chip. Packets are
// pulled from external first-word-fall-through input FIFOs (one per edge
// terminal), their destination row/column is decoded from the header, and the
// unmodified packet is written into the destination terminal's internal
// first-word-fall-through output FIFO. A round-robin arbiter accepts at most
// one packet per cycle.
//
// Header layout (pckg_sz >= 17):
//   [pckg_sz-1 : pckg_sz-8]   next-jump (ignored)
//   [pckg_sz-9 : pckg_sz-12]  destination row
//   [pckg_sz-13: pckg_sz-16]  destination column
//   [pckg_sz-17]              mode (ignored)
//   remaining bits            payload
//
// Terminal numbering (R = ROWS, C = COLUMS, k from 0):
//   top    k       -> (0,   k+1)
//   left   C+k     -> (k+1, 0)
//   bottom C+R+k   -> (R+1, k+1)
//   right  2C+R+k  -> (k+1, C+1)
// Destinations that are not an edge terminal are accepted and dropped.
//
// Optional feature: define MESH_BCAST_EN to enable broadcast. A packet whose
// {row,col} equals bdcst is then written to every terminal except its source,
// and only when all of those FIFOs have room. Without the macro such a packet
// is dropped like any other invalid destination.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous, active-high reset
//   data_out_i_in  in   NTRMS*pckg_sz  head word of each external input FIFO
//   pndng_i_in     in   NTRMS          external input FIFO non-empty flags
//   popin          out  NTRMS          one-hot consume strobe (combinational)
//   data_out       out  NTRMS*pckg_sz  head of each output FIFO (0 if empty)
//   pndng          out  NTRMS          output FIFO non-empty flags
//   pop            in   NTRMS          remove head of output FIFO at this edge
// -----------------------------------------------------------------------------
module mesh_fabric_model #(
  parameter int          ROWS       = 4,
  parameter int          COLUMS     = 4,
  parameter int          pckg_sz    = 32,
  parameter int          fifo_depth = 16,
  parameter logic [7:0]  bdcst      = 8'hFF,
  localparam int         NTRMS      = 2*ROWS + 2*COLUMS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NTRMS*pckg_sz-1:0] data_out_i_in,
  input  logic [NTRMS-1:0]         pndng_i_in,
  output logic [NTRMS-1:0]         popin,
  output logic [NTRMS*pckg_sz-1:0] data_out,
  output logic [NTRMS-1:0]         pndng,
  input  logic [NTRMS-1:0]         pop
);

  localparam int IDX_W = (NTRMS > 1) ? $clog2(NTRMS) : 1;
  localparam int PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CNT_W = $clog2(fifo_depth + 1);

`ifdef MESH_BCAST_EN
  localparam bit BCAST_EN = 1'b1;
`else
  localparam bit BCAST_EN = 1'b0;
`endif

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } dest_t;

  // Map a (row,col) coordinate to an edge-terminal index; valid=0 for
  // interior points, corners and anything outside the mesh ring.
  function automatic dest_t decode(input logic [3:0] row, input logic [3:0] col);
    int    r;
    int    c;
    dest_t d;
    r = int'(row);
    c = int'(col);
    d = '0;
    if (r == 0 && c >= 1 && c <= COLUMS) begin
      d.valid = 1'b1;
      d.idx   = IDX_W'(c - 1);
    end else if (c == 0 && r >= 1 && r <= ROWS) begin
      d.valid = 1'b1;
      d.idx   = IDX_W'(COLUMS + r - 1);
    end else if (r == ROWS + 1 && c >= 1 && c <= COLUMS) begin
      d.valid = 1'b1;
      d.idx   = IDX_W'(COLUMS + ROWS + c - 1);
    end else if (c == COLUMS + 1 && r >= 1 && r <= ROWS) begin
      d.valid = 1'b1;
      d.idx   = IDX_W'(2*COLUMS + ROWS + r - 1);
    end
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // Output FIFO state
  // ---------------------------------------------------------------------------
  logic [pckg_sz-1:0] mem [NTRMS][fifo_depth];
  logic [PTR_W-1:0]   wr_q  [NTRMS];
  logic [PTR_W-1:0]   wr_d  [NTRMS];
  logic [PTR_W-1:0]   rd_q  [NTRMS];
  logic [PTR_W-1:0]   rd_d  [NTRMS];
  logic [CNT_W-1:0]   cnt_q [NTRMS];
  logic [CNT_W-1:0]   cnt_d [NTRMS];
  logic [NTRMS-1:0]   room;

  logic [IDX_W-1:0]   rr_q;
  logic [IDX_W-1:0]   rr_d;

  // ---------------------------------------------------------------------------
  // Header decode and per-source acceptance
  // ---------------------------------------------------------------------------
  logic [pckg_sz-1:0] in_word [NTRMS];
  dest_t              src_dest [NTRMS];
  logic [NTRMS-1:0]   src_bcast;
  logic [NTRMS-1:0]   accept;

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned; that is what keeps latches from being inferred.
  always_comb begin
    logic [7:0] hdr;
    logic       hit;
    room      = '0;
    src_bcast = '0;
    accept    = '0;
    hdr       = '0;
    hit       = 1'b0;
    for (int j = 0; j < NTRMS; j++) begin
      room[j] = cnt_q[j] < CNT_W'(fifo_depth);
    end
    for (int i = 0; i < NTRMS; i++) begin
      in_word[i]  = data_out_i_in[i*pckg_sz +: pckg_sz];
      hdr         = in_word[i][pckg_sz-9 -: 8];
      hit         = (hdr == bdcst);
      src_bcast[i] = BCAST_EN && hit;
      src_dest[i]  = decode(hdr[7:4], hdr[3:0]);
      // The broadcast code never addresses a terminal, even if it happens to
      // alias a ring coordinate under a non-default bdcst.
      if (hit) src_dest[i].valid = 1'b0;
      if (src_bcast[i]) begin
        // Source bit forced to 1: a broadcast does not need room at home.
        accept[i] = pndng_i_in[i] && (&(room | (NTRMS'(1) << i)));
      end else begin
        accept[i] = pndng_i_in[i] && (!src_dest[i].valid || room[src_dest[i].idx]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first acceptable source at or after rr_q
  // ---------------------------------------------------------------------------
  logic             grant_found;
  logic             grant_ok;
  logic [IDX_W-1:0] grant_idx;

  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int off = 0; off < NTRMS; off++) begin
      cand = int'(rr_q) + off;
      if (cand >= NTRMS) cand = cand - NTRMS;
      cand_idx = IDX_W'(cand);
      if (!grant_found && accept[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Nothing is consumed while reset is held, even between clock edges.
  assign grant_ok = grant_found && !reset;
  assign popin    = grant_ok ? (NTRMS'(1) << grant_idx) : '0;

  always_comb begin
    rr_d = rr_q;
    if (grant_ok) begin
      rr_d = (grant_idx == IDX_W'(NTRMS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Push vector: which output FIFOs receive the granted word this edge
  // ---------------------------------------------------------------------------
  logic [NTRMS-1:0]   push_vec;
  logic [pckg_sz-1:0] push_data;

  always_comb begin
    push_vec  = '0;
    push_data = in_word[grant_idx];
    if (grant_ok) begin
      if (src_bcast[grant_idx]) begin
        push_vec = ~(NTRMS'(1) << grant_idx);
      end else if (src_dest[grant_idx].valid) begin
        push_vec = NTRMS'(1) << src_dest[grant_idx].idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO pointer/count next state
  // ---------------------------------------------------------------------------
  always_comb begin
    logic do_pop;
    do_pop = 1'b0;
    for (int j = 0; j < NTRMS; j++) begin
      // Pop on an empty FIFO is ignored; full check above uses pre-pop count.
      do_pop   = pop[j] && (cnt_q[j] != '0);
      wr_d[j]  = wr_q[j];
      rd_d[j]  = rd_q[j];
      cnt_d[j] = cnt_q[j];
      if (push_vec[j]) begin
        wr_d[j] = (wr_q[j] == PTR_W'(fifo_depth - 1)) ? '0 : wr_q[j] + 1'b1;
      end
      if (do_pop) begin
        rd_d[j] = (rd_q[j] == PTR_W'(fifo_depth - 1)) ? '0 : rd_q[j] + 1'b1;
      end
      case ({push_vec[j], do_pop})
        2'b10:   cnt_d[j] = cnt_q[j] + 1'b1;
        2'b01:   cnt_d[j] = cnt_q[j] - 1'b1;
        default: cnt_d[j] = cnt_q[j];
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= '0;
      for (int j = 0; j < NTRMS; j++) begin
        wr_q[j]  <= '0;
        rd_q[j]  <= '0;
        cnt_q[j] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int j = 0; j < NTRMS; j++) begin
        wr_q[j]  <= wr_d[j];
        rd_q[j]  <= rd_d[j];
        cnt_q[j] <= cnt_d[j];
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; cnt_q decides which
  // entries are live, and outputs are masked to 0 when a FIFO is empty.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NTRMS; j++) begin
      if (push_vec[j]) mem[j][wr_q[j]] <= push_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: FWFT head, forced to 0 when empty
  // ---------------------------------------------------------------------------
  always_comb begin
    pndng    = '0;
    data_out = '0;
    for (int j = 0; j < NTRMS; j++) begin
      pndng[j] = (cnt_q[j] != '0);
      if (pndng[j]) data_out[j*pckg_sz +: pckg_sz] = mem[j][rd_q[j]];
    end
  end

endmodule

// File: tb/tb_mesh_fabric_model.sv
// -----------------------------------------------------------------------------
// tb_mesh_fabric_model
//
// Directed bench for mesh_fabric_model (4x4 mesh, 16 terminals, 32-bit
// packets). Input FIFOs are modelled as queues; when the DUT grants a source
// the bench pushes that packet's hand-specified destinations into per-terminal
// expectation queues, and an independent monitor compares every word the DUT
// presents on an output it is draining.
// -----------------------------------------------------------------------------
module tb_mesh_fabric_model;

  localparam int R = 4;
  localparam int C = 4;
  localparam int W = 32;
  localparam int N = 2*R + 2*C;
  localparam int D = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   pend_in;
  logic [N-1:0]   popin;
  logic [N*W-1:0] data_out;
  logic [N-1:0]   pndng;
  logic [N-1:0]   pop;

  always #5 clk = ~clk;

  mesh_fabric_model #(
    .ROWS       (R),
    .COLUMS     (C),
    .pckg_sz    (W),
    .fifo_depth (D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_out_i_in (data_in),
    .pndng_i_in    (pend_in),
    .popin         (popin),
    .data_out      (data_out),
    .pndng         (pndng),
    .pop           (pop)
  );

  typedef struct {
    logic [W-1:0] data;
    logic [N-1:0] dst;
  } pkt_t;

  pkt_t         in_q  [N][$];
  logic [W-1:0] exp_q [N][$];
  logic [N-1:0] drain_en;
  logic [N-1:0] last_grant;
  int           n_checks = 0;
  int           n_pass   = 0;

`ifdef MESH_BCAST_EN
  localparam logic [N-1:0] BCAST_MASK = 16'hFFDF;
`else
  localparam logic [N-1:0] BCAST_MASK = 16'h0000;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      pend_in[i] = (in_q[i].size() != 0);
      data_in[i*W +: W] = (in_q[i].size() != 0) ? in_q[i][0].data : '0;
    end
  endtask

  task automatic send(input int src, input logic [W-1:0] data, input logic [N-1:0] dst);
    pkt_t p;
    p.data = data;
    p.dst  = dst;
    in_q[src].push_back(p);
    drive();
  endtask

  // One clock: sample grants at the falling edge, record expectations, then
  // retire the consumed input words just after the rising edge.
  task automatic step();
    logic [N-1:0] g;
    @(negedge clk);
    g = popin;
    last_grant = g;
    if (g != '0) check("grant_onehot", 64'($countones(g)), 64'd1);
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        check("grant_pending", 64'(in_q[i].size() != 0), 64'd1);
        if (in_q[i].size() != 0) begin
          for (int j = 0; j < N; j++) begin
            if (in_q[i][0].dst[j]) exp_q[j].push_back(in_q[i][0].data);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (g[i] && in_q[i].size() != 0) void'(in_q[i].pop_front());
    end
    drive();
  endtask

  // Monitor: compares and pops every output that is being drained.
  initial begin
    logic [N-1:0] pop_n;
    pop = '0;
    forever begin
      @(negedge clk);
      pop_n = '0;
      for (int j = 0; j < N; j++) begin
        if (!reset && pndng[j]) begin
          if (exp_q[j].size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_out t%0d: got %0h expected no data", j, data_out[j*W +: W]);
            pop_n[j] = 1'b1;
          end else if (drain_en[j]) begin
            check($sformatf("out_t%0d", j), 64'(data_out[j*W +: W]), 64'(exp_q[j][0]));
            void'(exp_q[j].pop_front());
            pop_n[j] = 1'b1;
          end
        end
      end
      pop = pop_n;
    end
  end

  initial begin
    int left;
    reset    = 1'b1;
    drain_en = '1;
    pend_in  = '0;
    data_in  = '0;

    // Reset state, with a packet already presented that must not be consumed.
    send(0, 32'h00520ABC, 16'h0200);
    #2;
    check("rst_pndng", 64'(pndng), 64'd0);
    check("rst_dout_zero", 64'(data_out == '0), 64'd1);
    check("rst_popin", 64'(popin), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold_popin", 64'(popin), 64'd0);
    reset = 1'b0;
    #1;
    check("uni_popin_comb", 64'(popin), 64'h0001);

    // Unicast 0 -> (5,2) = terminal 9.
    step();
    check("uni_grant", 64'(last_grant), 64'h0001);
    check("uni_pndng9", 64'(pndng[9]), 64'd1);
    check("uni_dout9", 64'(data_out[9*W +: W]), 64'h00520ABC);

    // Fairness: rr=1, sources 3, 7, 12 granted in order.
    send(3,  32'h00011111, 16'h0001);
    send(7,  32'h00022222, 16'h0002);
    send(12, 32'h00033333, 16'h0004);
    step();
    check("fair_1", 64'(last_grant), 64'h0008);
    check("uni_popped9", 64'(pndng[9]), 64'd0);
    step();
    check("fair_2", 64'(last_grant), 64'h0080);
    step();
    check("fair_3", 64'(last_grant), 64'h1000);

    // Self-destination: terminal 0 is (0,1).
    send(0, 32'h00014444, 16'h0001);
    step();
    check("self_grant", 64'(last_grant), 64'h0001);
    repeat (2) step();

    // Backpressure: 17 packets from terminal 10 to terminal 4 (1,0).
    drain_en[4] = 1'b0;
    for (int k = 0; k < 17; k++) send(10, {8'h00, 8'h10, 16'(k)}, 16'h0010);
    for (int k = 0; k < 16; k++) begin
      step();
      check($sformatf("bp_acc%0d", k), 64'(last_grant), 64'h0400);
    end
    repeat (3) begin
      step();
      check("bp_full", 64'(last_grant), 64'd0);
    end
    check("bp_pndng4", 64'(pndng[4]), 64'd1);
    drain_en[4] = 1'b1;
    step();
    check("bp_prepop", 64'(last_grant), 64'd0);
    drain_en[4] = 1'b0;
    step();
    check("bp_after_pop", 64'(last_grant), 64'h0400);
    drain_en = '1;
    repeat (20) step();
    check("bp_drained", 64'(pndng), 64'd0);

    // Invalid destinations: interior (2,2) and corner (0,0). rr=11 -> 1 first.
    send(6, 32'h00225555, 16'h0000);
    send(1, 32'h00006666, 16'h0000);
    step();
    check("inv_grant1", 64'(last_grant), 64'h0002);
    step();
    check("inv_grant6", 64'(last_grant), 64'h0040);
    repeat (3) step();
    check("inv_no_pndng", 64'(pndng), 64'd0);

    // Broadcast code from terminal 5.
    send(5, 32'h00FF7777, BCAST_MASK);
    step();
    check("bc_grant", 64'(last_grant), 64'h0020);
    check("bc_pndng", 64'(pndng), 64'(BCAST_MASK));
    repeat (3) step();
    check("bc_drained", 64'(pndng), 64'd0);

    // Reset mid-traffic: FIFOs hold data, a packet is pending at terminal 3.
    drain_en = '0;
    send(2, 32'h0052AAAA, 16'h0200);
    send(8, 32'h0001BBBB, 16'h0001);
    step();
    step();
    check("mid_fill", 64'(pndng), 64'h0201);
    send(3, 32'h0003CCCC, 16'h0004);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_pndng", 64'(pndng), 64'd0);
    check("mid_rst_dout_zero", 64'(data_out == '0), 64'd1);
    check("mid_rst_popin", 64'(popin), 64'd0);
    for (int j = 0; j < N; j++) exp_q[j].delete();
    step();
    check("mid_rst_nogrant", 64'(last_grant), 64'd0);
    reset = 1'b0;
    step();
    check("mid_after_rst", 64'(last_grant), 64'h0008);
    drain_en = '1;
    repeat (4) step();

    left = 0;
    for (int j = 0; j < N; j++) left += exp_q[j].size();
    check("end_scoreboard_empty", 64'(left), 64'd0);
    left = 0;
    for (int i = 0; i < N; i++) left += in_q[i].size();
    check("end_inputs_consumed", 64'(left), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mesh_fabric_model.md
Name: mesh_fabric_model

Overview:
- Terminal-level model of a ROWS x COLUMS mesh network-on-chip with 2*ROWS+2*COLUMS edge terminals.
- Pulls packets from external per-terminal input FIFOs (first-word-fall-through) and decodes the destination row/column from the packet header.
- Delivers each packet unchanged into the destination terminal's internal output FIFO, which the environment drains with pop.
- Sits between the verification environment's input FIFO models and its output monitors.

Parameters:
- ROWS, 4, mesh rows
- COLUMS, 4, mesh columns
- pckg_sz, 32, packet width in bits (minimum 17)
- fifo_depth, 16, entries per output FIFO
- bdcst, 8'hFF, {row,col} value meaning broadcast
- Derived: NTRMS = 2*ROWS+2*COLUMS (16 by default)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- data_out_i_in  input  NTRMS*pckg_sz  head word of terminal i's external input FIFO, bits [i*pckg_sz +: pckg_sz]
- pndng_i_in  input  NTRMS  bit i: terminal i's input FIFO is non-empty
- popin  output  NTRMS  bit i: DUT consumes terminal i's head word this cycle
- data_out  output  NTRMS*pckg_sz  head of terminal i's output FIFO
- pndng  output  NTRMS  bit i: terminal i's output FIFO is non-empty
- pop  input  NTRMS  bit i: environment removes head of output FIFO i at this edge

Behaviour:
- Header fields:
  - [pckg_sz-1:pckg_sz-8] next-jump, ignored.
  - [pckg_sz-9:pckg_sz-12] dest row.
  - [pckg_sz-13:pckg_sz-16] dest col.
  - [pckg_sz-17] mode, ignored.
  - Remaining bits are payload.
- Terminal map, for index k from 0:
  - Top: index k = 0..C-1 is (row 0, col k+1).
  - Left: index C+k is (row k+1, col 0).
  - Bottom: index C+R+k is (row R+1, col k+1).
  - Right: index 2C+R+k is (row k+1, col C+1).
- Arbiter:
  - Round-robin pointer rr, reset 0.
  - Each cycle, scan from rr for the first terminal i with pndng_i_in[i]=1 whose destination(s) are accepted (see below).
  - If found: popin[i]=1, combinational and one-hot; rr<=i+1 mod NTRMS.
  - Otherwise popin is all-zero and rr is unchanged.
  - At most one packet is accepted per cycle.
- Acceptance:
  - Unicast: the destination output FIFO count < fifo_depth.
  - Invalid coordinates (not an edge terminal, e.g. interior (1,1) or corner (0,0)): always accepted, popped and dropped.
  - Self-destination is delivered to itself.
- Enqueue: on the edge where popin[i]=1, data_out_i_in[i] is written unmodified to the destination FIFO.
- Latency: pndng rises and data_out is valid in the cycle after the popin cycle.
- Output FIFOs:
  - First-word-fall-through; data_out[i] is the head, or 0 when empty.
  - pop on an empty FIFO is ignored.
  - Same-cycle push and pop on a FIFO are both honoured.
  - Full test uses the pre-pop count; no pop credit.
  - Wrap-around pointers; no overflow is possible.
- Reset (asynchronous, active-high): all FIFOs emptied, rr=0, pndng=0, data_out=0.
  - popin is 0 while reset is asserted.
  - A packet presented during reset is not consumed.

Optional Feature:
- Macro MESH_BCAST_EN enables broadcast.
- Defined: {row,col}==bdcst targets every terminal except the source.
  - Accepted only when all those FIFOs have room.
  - Enqueued into all of them at the same edge.
- Undefined: a bdcst packet is treated as an invalid destination, popped and dropped.

Test Plan:
- Reset: assert reset mid-traffic with FIFOs holding data -> pndng=0, data_out=0, popin=0 immediately, without waiting for a clock edge.
- Unicast: terminal 0 presents 32'h00_52_0ABC (row 5, col 2) -> popin[0] for 1 cycle; next cycle pndng[9]=1, data_out[9]=32'h00520ABC; pop[9] -> pndng[9]=0.
- Fairness: terminals 3, 7 and 12 all pending to distinct destinations -> popin pulses in order 3, 7, 12 on consecutive cycles.
- Backpressure: 17 packets to terminal 4 (row 1, col 0) with no pops -> 16 accepted, then popin[src] stays 0; one pop[4] -> the 17th is accepted the next cycle.
- Invalid destination: packet to (row 2, col 2) -> popin pulses, no pndng bit ever rises.
- With MESH_BCAST_EN: terminal 5 sends header {8'h00,8'hFF} -> the next cycle pndng = 16'hFFDF, identical data on all 15 terminals.
- Without MESH_BCAST_EN: the same broadcast packet is dropped.
